pcpi_scheduler: RTL and testbench

//  Arbitrates the core's PCPI port across N_UNITS custom-extension units. Claims CUSTOM-0 insns

---
 rtl/pcpi_pkg.sv | 19 +
 rtl/pcpi_timeout_ctr.sv | 31 +++
 rtl/pcpi_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_pcpi_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_pkg.sv
// Shared definitions for the PCPI scheduler: FSM state encoding, the
// CUSTOM-0 major opcode, and where the unit index sits in the instruction.
package pcpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BUSY    = 3'd1,
    ST_RESP    = 3'd2,
    ST_ABORT   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // RISC-V CUSTOM-0 major opcode.
  localparam logic [6:0] CUSTOM0_OPCODE = 7'b0001011;

  // Unit index is taken from the low bits of funct7.
  localparam int UNIT_IDX_LSB = 25;

endpackage

// File: rtl/pcpi_timeout_ctr.sv
// Watchdog counter for one dispatched operation. Cleared by load, advances
// while enabled, and flags expire during the last permitted enabled cycle.
module pcpi_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count enabled cycles since the last load; hold at the final value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/pcpi_scheduler.sv
// PCPI arbiter: claims CUSTOM-0 instructions whose funct7 index names an
// attached unit, issues the latched operands to that unit, waits for its
// completion (or aborts it on timeout) and returns a one-cycle result to
// the core. Also keeps op and busy-cycle statistics.
//
// Handshake: the core holds pcpi_valid and the insn/operands stable until it
// sees pcpi_ready or gives up. Toward a unit, unit_valid[i] stays high for the
// whole operation and the unit answers with a single-cycle unit_ready[i]
// together with unit_wr[i]/unit_rd; completion strobes from non-selected
// units are ignored. Withdrawing unit_valid (flush, abort, reset) cancels
// the operation and the unit must tolerate that.
module pcpi_scheduler
  import pcpi_pkg::*;
#(
  parameter int         N_UNITS        = 2,
  parameter int         IDX_W          = 3,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [6:0] CUSTOM_OPCODE  = CUSTOM0_OPCODE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pcpi_valid,
  input  logic [31:0]           pcpi_insn,
  input  logic [31:0]           pcpi_rs1,
  input  logic [31:0]           pcpi_rs2,
  output logic                  pcpi_wait,
  output logic                  pcpi_ready,
  output logic                  pcpi_wr,
  output logic [31:0]           pcpi_rd,
  output logic [N_UNITS-1:0]    unit_valid,
  output logic [31:0]           unit_insn,
  output logic [31:0]           unit_rs1,
  output logic [31:0]           unit_rs2,
  input  logic [N_UNITS-1:0]    unit_ready,
  input  logic [N_UNITS-1:0]    unit_wr,
  input  logic [32*N_UNITS-1:0] unit_rd,
  input  logic                  err_clr,
  output logic                  err_timeout,
  output logic [31:0]           ops_done,
  output logic [31:0]           busy_cycles
);

  state_t state;
  state_t state_next;

  logic [31:0]      insn_q;
  logic [31:0]      rs1_q;
  logic [31:0]      rs2_q;
  logic [IDX_W-1:0] sel_q;
  logic             wr_q;
  logic [31:0]      rd_q;

  logic [IDX_W-1:0]   req_idx;
  logic               claim;
  logic               load;
  logic               capture;
  logic               in_busy;
  logic               expire;
  logic               sel_ready;
  logic               sel_wr;
  logic [31:0]        sel_rd;
  logic [N_UNITS-1:0] sel_onehot;

  assign req_idx = pcpi_insn[UNIT_IDX_LSB +: IDX_W];
  assign claim   = pcpi_valid
                && (pcpi_insn[6:0] == CUSTOM_OPCODE)
                && (int'(req_idx) < N_UNITS);
  assign in_busy = (state == ST_BUSY);

  pcpi_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .enable (in_busy),
    .expire (expire)
  );

  // Pick the selected unit's completion, write-enable and result; others are ignored.
  always_comb begin
    sel_ready  = 1'b0;
    sel_wr     = 1'b0;
    sel_rd     = '0;
    sel_onehot = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (sel_q == IDX_W'(i)) begin
        sel_ready     = unit_ready[i];
        sel_wr        = unit_wr[i];
        sel_rd        = unit_rd[32*i +: 32];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: flush beats completion, completion beats timeout.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (claim) begin
          state_next = ST_BUSY;
          load       = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!pcpi_valid) begin
          state_next = ST_IDLE;
        end else if (sel_ready) begin
          state_next = ST_RESP;
          capture    = 1'b1;
        end else if (expire) begin
          state_next = ST_ABORT;
        end
      end
      ST_RESP:  state_next = ST_RELEASE;
      ST_ABORT: state_next = ST_RELEASE;
      ST_RELEASE: begin
        if (!pcpi_valid) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Latch the request on claim and the unit's answer on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      insn_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      sel_q  <= '0;
      wr_q   <= 1'b0;
      rd_q   <= '0;
    end else begin
      if (load) begin
        insn_q <= pcpi_insn;
        rs1_q  <= pcpi_rs1;
        rs2_q  <= pcpi_rs2;
        sel_q  <= req_idx;
      end
      if (capture) begin
        wr_q <= sel_wr;
        rd_q <= sel_rd;
      end
    end
  end

  // Statistics and the sticky timeout flag; a new timeout overrides err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done    <= '0;
      busy_cycles <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ST_RESP) begin
        ops_done <= ops_done + 32'd1;
      end
      if (in_busy) begin
        busy_cycles <= busy_cycles + 32'd1;
      end
      if (state == ST_ABORT) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end
    end
  end

  // Outputs are decoded from registered state so they appear one cycle after claim.
  assign pcpi_wait  = in_busy;
  assign pcpi_ready = (state == ST_RESP);
  assign pcpi_wr    = (state == ST_RESP) && wr_q;
  assign pcpi_rd    = (state == ST_RESP) ? rd_q : 32'd0;
  assign unit_valid = in_busy ? sel_onehot : '0;
  assign unit_insn  = insn_q;
  assign unit_rs1   = rs1_q;
  assign unit_rs2   = rs2_q;

endmodule

// File: tb/tb_pcpi_scheduler.sv
// Bench for pcpi_scheduler (N_UNITS=2, TIMEOUT_CYCLES=64): a vector table of
// directed operations, randomized operations checked against an outcome model,
// and hand-written flush / reset / error-clear sequences.
module tb_pcpi_scheduler;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pcpi_valid = 1'b0;
  logic [31:0]   pcpi_insn = '0;
  logic [31:0]   pcpi_rs1 = '0;
  logic [31:0]   pcpi_rs2 = '0;
  logic          pcpi_wait;
  logic          pcpi_ready;
  logic          pcpi_wr;
  logic [31:0]   pcpi_rd;
  logic [N-1:0]  unit_valid;
  logic [31:0]   unit_insn;
  logic [31:0]   unit_rs1;
  logic [31:0]   unit_rs2;
  logic [N-1:0]  unit_ready = '0;
  logic [N-1:0]  unit_wr = '0;
  logic [32*N-1:0] unit_rd = '0;
  logic          err_clr = 1'b0;
  logic          err_timeout;
  logic [31:0]   ops_done;
  logic [31:0]   busy_cycles;

  pcpi_scheduler #(
    .N_UNITS        (N),
    .IDX_W          (3),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pcpi_valid  (pcpi_valid),
    .pcpi_insn   (pcpi_insn),
    .pcpi_rs1    (pcpi_rs1),
    .pcpi_rs2    (pcpi_rs2),
    .pcpi_wait   (pcpi_wait),
    .pcpi_ready  (pcpi_ready),
    .pcpi_wr     (pcpi_wr),
    .pcpi_rd     (pcpi_rd),
    .unit_valid  (unit_valid),
    .unit_insn   (unit_insn),
    .unit_rs1    (unit_rs1),
    .unit_rs2    (unit_rs2),
    .unit_ready  (unit_ready),
    .unit_wr     (unit_wr),
    .unit_rd     (unit_rd),
    .err_clr     (err_clr),
    .err_timeout (err_timeout),
    .ops_done    (ops_done),
    .busy_cycles (busy_cycles)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int m_ops  = 0;
  int m_busy = 0;
  bit m_err  = 0;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          delay;      // BUSY cycle in which the unit answers; 0 = never
    bit          noise;      // pulse the other unit's ready in the first BUSY cycle
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [1:0]  wr;
    bit          exp_claim;
    bit          exp_ready;
    logic [31:0] exp_rd;
    logic        exp_wr;
    int          exp_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Outcome model from the scheduler rules: who is claimed, whether the unit
  // answers before the 64-cycle limit, and how many BUSY cycles are spent.
  task automatic model(input vec_t v, output vec_t r);
    int idx;
    r = v;
    idx = int'(v.insn[27:25]);
    r.exp_claim = (v.insn[6:0] == 7'h0B) && (idx < N);
    r.exp_ready = r.exp_claim && (v.delay >= 1) && (v.delay <= 64);
    r.exp_busy  = !r.exp_claim ? 0 : (r.exp_ready ? v.delay : 64);
    r.exp_rd    = r.exp_ready ? ((idx == 1) ? v.rd1 : v.rd0) : 32'd0;
    r.exp_wr    = r.exp_ready ? v.wr[idx % 2] : 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input vec_t v, input string tag);
    int   sel;
    int   busy_seen;
    int   ready_at;
    bit   saw_wait;
    bit   saw_ready;
    bit   uv_bad;
    bit   rd_bad;
    bit   held_bad;
    logic [31:0] got_rd;
    logic [31:0] exp_rd;
    logic        got_wr;
    logic [N-1:0] exp_uv;

    sel = int'(v.insn[27:25]);
    busy_seen = 0; ready_at = 0; saw_wait = 0; saw_ready = 0;
    uv_bad = 0; rd_bad = 0; held_bad = 0; got_rd = '0; got_wr = 1'b0;
    if (v.exp_ready) exp_q.push_back(v.exp_rd);

    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = v.insn;
    pcpi_rs1   = v.rs1;
    pcpi_rs2   = v.rs2;
    unit_ready = '0;
    unit_wr    = v.wr;
    unit_rd    = {v.rd1, v.rd0};

    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      unit_ready = '0;
      if (pcpi_wait) begin
        saw_wait = 1;
        busy_seen++;
        exp_uv = '0;
        if (sel < N) exp_uv[sel] = 1'b1;
        if (unit_valid !== exp_uv || unit_insn !== v.insn ||
            unit_rs1 !== v.rs1 || unit_rs2 !== v.rs2) uv_bad = 1;
      end else if (unit_valid !== '0) begin
        uv_bad = 1;
      end
      if (pcpi_ready) begin
        saw_ready = 1;
        ready_at  = c;
        got_rd    = pcpi_rd;
        got_wr    = pcpi_wr;
        break;
      end
      if (pcpi_rd !== 32'd0 || pcpi_wr !== 1'b0) rd_bad = 1;
      if (saw_wait && !pcpi_wait) break;
      if (pcpi_wait && sel < N) begin
        if (busy_seen == v.delay) unit_ready[sel] = 1'b1;
        if (v.noise && busy_seen == 1) unit_ready[1 - sel] = 1'b1;
      end
    end
    unit_ready = '0;

    check({tag, " claim"}, 32'(saw_wait), 32'(v.exp_claim));
    check({tag, " ready"}, 32'(saw_ready), 32'(v.exp_ready));
    check({tag, " busy_len"}, 32'(busy_seen), 32'(v.exp_busy));
    check({tag, " unit_if"}, 32'(uv_bad), 32'd0);
    check({tag, " rd_idle"}, 32'(rd_bad), 32'd0);
    if (v.exp_ready) begin
      exp_rd = exp_q.pop_front();
      if (saw_ready) begin
        check({tag, " pcpi_rd"}, got_rd, exp_rd);
        check({tag, " pcpi_wr"}, 32'(got_wr), 32'(v.exp_wr));
        check({tag, " latency"}, 32'(ready_at), 32'(v.exp_busy + 1));
      end
    end

    // Keep the request up: the same insn must not be re-dispatched.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (pcpi_wait || pcpi_ready || unit_valid !== '0) held_bad = 1;
    end
    check({tag, " no_redispatch"}, 32'(held_bad), 32'd0);
    pcpi_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    if (v.exp_claim) begin
      m_busy += v.exp_busy;
      if (v.exp_ready) m_ops++;
      else m_err = 1;
    end
    check({tag, " ops_done"}, ops_done, 32'(m_ops));
    check({tag, " busy_cycles"}, busy_cycles, 32'(m_busy));
    check({tag, " err_timeout"}, 32'(err_timeout), 32'(m_err));
  endtask

  task automatic clear_err(input string tag);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err = 0;
    check({tag, " err_clr"}, 32'(err_timeout), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    vec_t r;
    int   busy_seen;
    bit   done;

    //            insn          rs1 rs2 dly nz rd0           rd1           wr     clm rdy exp_rd        ewr busy
    vecs[0] = '{32'h0200000B, 5,  7,  4,  0, 32'h0,        32'h0000000C, 2'b10, 1,  1,  32'h0000000C, 1,  4};
    vecs[1] = '{32'h0A00000B, 1,  2,  1,  0, 32'h11,       32'h22,       2'b11, 0,  0,  32'h0,        0,  0};
    vecs[2] = '{32'h0000000B, 3,  4,  0,  0, 32'h33,       32'h44,       2'b11, 1,  0,  32'h0,        0,  64};
    vecs[3] = '{32'h0200000B, 9,  9,  64, 0, 32'h55,       32'hCAFE0001, 2'b10, 1,  1,  32'hCAFE0001, 1,  64};
    vecs[4] = '{32'h0200000B, 6,  8,  3,  1, 32'hDEAD0000, 32'h00001234, 2'b01, 1,  1,  32'h00001234, 0,  3};
    vecs[5] = '{32'h0000000B, 1,  1,  1,  0, 32'hA5A5A5A5, 32'h77,       2'b01, 1,  1,  32'hA5A5A5A5, 1,  1};
    vecs[6] = '{32'h00000033, 1,  1,  1,  0, 32'h1,        32'h2,        2'b11, 0,  0,  32'h0,        0,  0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset pcpi_wait", 32'(pcpi_wait), 32'd0);
    check("reset pcpi_ready", 32'(pcpi_ready), 32'd0);
    check("reset pcpi_rd", pcpi_rd, 32'd0);
    check("reset unit_valid", 32'(unit_valid), 32'd0);
    check("reset unit_insn", unit_insn, 32'd0);
    check("reset counters", ops_done | busy_cycles, 32'd0);
    check("reset err", 32'(err_timeout), 32'd0);
    rst = 1'b0;

    // Table-driven directed vectors
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
      if (i == 2) clear_err("vec2");
    end

    // Flush mid-BUSY: back to IDLE, no error, no op counted
    v = vecs[3];
    v.delay = 0;
    @(negedge clk);
    pcpi_valid = 1'b1; pcpi_insn = v.insn; pcpi_rs1 = v.rs1; pcpi_rs2 = v.rs2;
    busy_seen = 0;
    for (int c = 0; c < 20 && busy_seen < 5; c++) begin
      @(negedge clk);
      if (pcpi_wait) busy_seen++;
    end
    check("flush setup", 32'(busy_seen), 32'd5);
    pcpi_valid = 1'b0;
    @(negedge clk);
    check("flush wait", 32'(pcpi_wait), 32'd0);
    check("flush unit_valid", 32'(unit_valid), 32'd0);
    m_busy += 5;
    @(negedge clk);
    check("flush ops", ops_done, 32'(m_ops));
    check("flush busy", busy_cycles, 32'(m_busy));
    check("flush err", 32'(err_timeout), 32'(m_err));

    // Timeout and err_clr in the same cycle: the timeout sets the flag
    @(negedge clk);
    pcpi_valid = 1'b1; pcpi_insn = 32'h0000000B; pcpi_rs1 = 1; pcpi_rs2 = 2;
    busy_seen = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (pcpi_wait) busy_seen++;
      else if (busy_seen > 0) done = 1;
    end
    check("setwins abort_seen", 32'(done), 32'd1);
    check("setwins busy_len", 32'(busy_seen), 32'd64);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("setwins err", 32'(err_timeout), 32'd1);
    pcpi_valid = 1'b0;
    m_busy += 64;
    m_err = 1;
    repeat (2) @(negedge clk);
    check("setwins busy", busy_cycles, 32'(m_busy));
    clear_err("setwins");

    // Randomized operations against the outcome model
    for (int i = 0; i < 24; i++) begin
      int k;
      v = vecs[0];
      v.insn = $urandom();
      if ($urandom_range(0, 3) != 0) v.insn[6:0] = 7'h0B;
      v.insn[27:25] = 3'($urandom_range(0, 2));
      v.rs1 = $urandom();
      v.rs2 = $urandom();
      k = $urandom_range(0, 9);
      v.delay = (k == 0) ? 0 : (k == 1) ? 64 : (k == 2) ? 65 : $urandom_range(1, 8);
      v.noise = 1'($urandom_range(0, 1));
      v.rd0 = $urandom();
      v.rd1 = $urandom();
      v.wr  = 2'($urandom_range(0, 3));
      model(v, r);
      run_op(r, $sformatf("rand%0d", i));
      if (m_err) clear_err($sformatf("rand%0d", i));
    end

    // Asynchronous reset in BUSY: outputs drop without waiting for a clock edge
    @(negedge clk);
    pcpi_valid = 1'b1; pcpi_insn = 32'h0200000B; pcpi_rs1 = 5; pcpi_rs2 = 7;
    busy_seen = 0;
    for (int c = 0; c < 20 && busy_seen < 3; c++) begin
      @(negedge clk);
      if (pcpi_wait) busy_seen++;
    end
    check("rstbusy setup", 32'(busy_seen), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("rstbusy wait", 32'(pcpi_wait), 32'd0);
    check("rstbusy unit_valid", 32'(unit_valid), 32'd0);
    check("rstbusy ready", 32'(pcpi_ready), 32'd0);
    check("rstbusy counters", ops_done | busy_cycles, 32'd0);
    check("rstbusy err", 32'(err_timeout), 32'd0);
    m_ops = 0; m_busy = 0; m_err = 0;
    @(negedge clk);
    pcpi_valid = 1'b0;
    rst = 1'b0;
    run_op(vecs[0], "after_rst");

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
